// File: rtl/control_pkg.sv
// Shared constants and types for the RV32 main decoder and its ALU-control sub-block.
package control_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

endpackage

// File: rtl/control_alu_ctrl.sv
// ALU control: maps aluop and the {instr[30], funct3} select to a 4-bit ALU code.
module alu_ctrl
  import control_pkg::*;
(
  input  aluop_e      aluop,
  input  logic [3:0]  alu_sel,
  output logic [3:0]  aluctrl,
  output logic        rtype_illegal
);

  always_comb begin
    aluctrl       = ALU_ADD;
    rtype_illegal = 1'b0;
    unique case (aluop)
      ALUOP_ADD: aluctrl = ALU_ADD;
      ALUOP_SUB: aluctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (alu_sel)
          4'b0000: aluctrl = ALU_ADD;
          4'b1000: aluctrl = ALU_SUB;
          4'b0111: aluctrl = ALU_AND;
          4'b0110: aluctrl = ALU_OR;
          default: rtype_illegal = 1'b1;  // unsupported op still executes as add
        endcase
      end
      default: aluctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control.sv
// Main decoder for the single-cycle RV32 datapath (lw, sw, beq, add/sub/and/or).
// Optional strict R-type funct7 checking is enabled with CONTROL_RTYPE_STRICT_EN.
module control
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic        branch,
  output logic        memread,
  output logic        memtoreg,
  output logic [3:0]  aluctrl,
  output logic        alusrc,
  output logic        memwrite,
  output logic        regwrite,
  output logic        illegal,
  output logic        illegal_seen
);

  logic [6:0] opcode;
  logic [3:0] alu_sel;
  aluop_e     aluop;
  logic       rtype_hit;
  logic       opcode_bad;
  logic       regwrite_base;
  logic       rtype_illegal;
  logic       funct7_bad;
  logic       rtype_reject;
  logic       illegal_seen_q;
  logic       illegal_seen_d;
  logic       unused_instr;

  assign opcode  = instr[6:0];
  assign alu_sel = {instr[30], instr[14:12]};

  // Register and immediate fields are not needed by the decoder.
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  always_comb begin
    alusrc        = 1'b0;
    memtoreg      = 1'b0;
    regwrite_base = 1'b0;
    memread       = 1'b0;
    memwrite      = 1'b0;
    branch        = 1'b0;
    aluop         = ALUOP_ADD;
    rtype_hit     = 1'b0;
    opcode_bad    = 1'b0;
    case (opcode)
      OP_LOAD: begin
        alusrc        = 1'b1;
        memtoreg      = 1'b1;
        regwrite_base = 1'b1;
        memread       = 1'b1;
      end
      OP_STORE: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
      end
      OP_BRANCH: begin
        branch = 1'b1;
        aluop  = ALUOP_SUB;
      end
      OP_RTYPE: begin
        regwrite_base = 1'b1;
        aluop         = ALUOP_FUNCT;
        rtype_hit     = 1'b1;
      end
      default: opcode_bad = 1'b1;
    endcase
  end

  alu_ctrl u_alu_ctrl (
    .aluop         (aluop),
    .alu_sel       (alu_sel),
    .aluctrl       (aluctrl),
    .rtype_illegal (rtype_illegal)
  );

`ifdef CONTROL_RTYPE_STRICT_EN
  // sub needs funct7 0100000; every other supported op needs all-zero funct7
  assign funct7_bad   = (alu_sel == 4'b1000) ? (instr[31:25] != FUNCT7_SUB)
                                             : (instr[31:25] != FUNCT7_BASE);
  assign rtype_reject = rtype_illegal | funct7_bad;
`else
  assign funct7_bad   = ^{instr[31], instr[29:25]} & 1'b0;
  assign rtype_reject = 1'b0;
`endif

  assign regwrite = regwrite_base & ~(rtype_hit & rtype_reject);
  assign illegal  = opcode_bad | (rtype_hit & (rtype_illegal | funct7_bad));

  assign illegal_seen_d = illegal_seen_q | illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_control.sv
// Directed self-checking bench for the control decoder and its sticky illegal flag.
module tb_control;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        branch;
  logic        memread;
  logic        memtoreg;
  logic [3:0]  aluctrl;
  logic        alusrc;
  logic        memwrite;
  logic        regwrite;
  logic        illegal;
  logic        illegal_seen;

  int checks = 0;
  int errors = 0;

  control dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .branch       (branch),
    .memread      (memread),
    .memtoreg     (memtoreg),
    .aluctrl      (aluctrl),
    .alusrc       (alusrc),
    .memwrite     (memwrite),
    .regwrite     (regwrite),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Vector order: alusrc, memtoreg, regwrite, memread, memwrite, branch, aluctrl
  task automatic run_vec(input string tag, input logic [31:0] ins,
                         input logic [9:0] exp_vec, input logic exp_ill);
    logic [9:0] got_vec;
    instr = ins;
    #1;
    got_vec = {alusrc, memtoreg, regwrite, memread, memwrite, branch, aluctrl};
    $display("vec %-10s instr=%h ctrl=%b illegal=%b", tag, ins, got_vec, illegal);
    check({tag, "_ctrl"}, {22'd0, got_vec}, {22'd0, exp_vec});
    check({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
  endtask

  initial begin
    rst   = 1'b1;
    instr = 32'h0080af03;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_seen", {31'd0, illegal_seen}, 32'd0);
    rst = 1'b0;

    run_vec("lw0", 32'h0080af03, 10'b1111000010, 1'b0);
    run_vec("lw1", 32'hff80af03, 10'b1111000010, 1'b0);
    run_vec("lw2", 32'h0200a283, 10'b1111000010, 1'b0);
    run_vec("lw_b30", 32'h4000a283, 10'b1111000010, 1'b0);
    check("lw_memtoreg", {31'd0, memtoreg}, 32'd1);
    run_vec("sw0", 32'h0020a223, 10'b1000100010, 1'b0);
    check("sw_memtoreg", {31'd0, memtoreg}, 32'd0);
    run_vec("sw1", 32'hfe20aa23, 10'b1000100010, 1'b0);
    run_vec("sw2", 32'h0020a023, 10'b1000100010, 1'b0);
    run_vec("beq0", 32'h00208463, 10'b0000010110, 1'b0);
    run_vec("beq1", 32'h00208663, 10'b0000010110, 1'b0);
    run_vec("beq2", 32'hfeb289e3, 10'b0000010110, 1'b0);
    run_vec("add", 32'h00208f33, 10'b0010000010, 1'b0);
    run_vec("sub", 32'h40208f33, 10'b0010000110, 1'b0);
    run_vec("and", 32'h0020ff33, 10'b0010000000, 1'b0);
    run_vec("or", 32'h0020ef33, 10'b0010000001, 1'b0);

    // Let several edges pass with only legal instructions applied.
    repeat (2) @(posedge clk);
    #1;
    check("legal_no_seen", {31'd0, illegal_seen}, 32'd0);

    // Sticky flag: addi is unsupported.
    @(negedge clk);
    run_vec("addi", 32'h00000013, 10'b0000000010, 1'b1);
    check("seen_before_edge", {31'd0, illegal_seen}, 32'd0);
    @(posedge clk);
    #1;
    check("seen_after_edge", {31'd0, illegal_seen}, 32'd1);
    run_vec("add_again", 32'h00208f33, 10'b0010000010, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("seen_sticky", {31'd0, illegal_seen}, 32'd1);

    // Asynchronous reset pulse mid-cycle.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("seen_async_clr", {31'd0, illegal_seen}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("seen_stays_clr", {31'd0, illegal_seen}, 32'd0);

`ifdef CONTROL_RTYPE_STRICT_EN
    run_vec("r_sll", 32'h00209f33, 10'b0000000010, 1'b1);
    run_vec("r_sel15", 32'h4020ff33, 10'b0000000010, 1'b1);
    run_vec("r_f7_01", 32'h02208f33, 10'b0000000010, 1'b1);
`else
    run_vec("r_sll", 32'h00209f33, 10'b0010000010, 1'b1);
    run_vec("r_sel15", 32'h4020ff33, 10'b0010000010, 1'b1);
    run_vec("r_f7_01", 32'h02208f33, 10'b0010000010, 1'b0);
`endif

    // Reset held across an edge while illegal is high: reset wins.
    @(negedge clk);
    instr = 32'h00000013;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wins", {31'd0, illegal_seen}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release", {31'd0, illegal_seen}, 32'd0);
    @(posedge clk);
    #1;
    check("seen_after_rst", {31'd0, illegal_seen}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
